// File: rtl/hwpe_dma_loader_pkg.sv
//------------------------------------------------------------------------------
// Module  : hwpe_dma_loader_pkg
// Brief   : FSM state encodings and bus width constants for the DMA loader.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package hwpe_dma_loader_pkg;

  localparam int ICB_DW = 32;
  localparam int ICB_MW = 4;
  localparam int DMA_DW = 64;

  localparam logic [2:0] DL_IDLE   = 3'd0;
  localparam logic [2:0] DL_CMD_LO = 3'd1;
  localparam logic [2:0] DL_RSP_LO = 3'd2;
  localparam logic [2:0] DL_CMD_HI = 3'd3;
  localparam logic [2:0] DL_RSP_HI = 3'd4;
  localparam logic [2:0] DL_WRITE  = 3'd5;
  localparam logic [2:0] DL_FIN    = 3'd6;

endpackage

`default_nettype wire

// File: rtl/hwpe_dma_loader.sv
//------------------------------------------------------------------------------
// Module  : hwpe_dma_loader
// Brief   : Descriptor DMA pulling 32-bit ICB words, packing pairs into 64-bit
//           little-endian HWPE SRAM writes.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hwpe_dma_loader
  import hwpe_dma_loader_pkg::*;
#(
  parameter int HWPE_AW = 16,
  parameter int LEN_W   = 16,
  parameter int SRC_AW  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SRC_AW-1:0]  src_addr,
  input  logic [HWPE_AW-1:0] dst_addr,
  input  logic [LEN_W-1:0]   len,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               icb_cmd_valid,
  input  logic               icb_cmd_ready,
  output logic [SRC_AW-1:0]  icb_cmd_addr,
  output logic               icb_cmd_read,
  output logic [ICB_DW-1:0]  icb_cmd_wdata,
  output logic [ICB_MW-1:0]  icb_cmd_wmask,
  input  logic               icb_rsp_valid,
  output logic               icb_rsp_ready,
  input  logic [ICB_DW-1:0]  icb_rsp_rdata,
  input  logic               icb_rsp_err,
  output logic               dma_wen,
  output logic [HWPE_AW-1:0] dma_wa,
  output logic [DMA_DW-1:0]  dma_wd
);

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [SRC_AW-1:0]  r_src_ptr;
  logic [SRC_AW-1:0]  w_src_nxt;
  logic [HWPE_AW-1:0] r_dst_ptr;
  logic [HWPE_AW-1:0] w_dst_nxt;
  logic [LEN_W-1:0]   r_remaining;
  logic [LEN_W-1:0]   w_remaining_nxt;
  logic [ICB_DW-1:0]  r_lo;
  logic               w_cmd_hs;
  logic               w_in_rsp;
  logic               w_accept;

  assign icb_cmd_read  = 1'b1;
  assign icb_cmd_wdata = '0;
  assign icb_cmd_wmask = '0;
  assign icb_rsp_ready = 1'b1;

  assign w_cmd_hs = icb_cmd_valid & icb_cmd_ready;
  assign w_in_rsp = (r_state == DL_RSP_LO) || (r_state == DL_RSP_HI);
  assign w_accept = (r_state == DL_IDLE) && start;

  always_comb begin
    w_state_nxt     = r_state;
    w_src_nxt       = r_src_ptr;
    w_dst_nxt       = r_dst_ptr;
    w_remaining_nxt = r_remaining;
    case (r_state)
      DL_IDLE: begin
        if (start) begin
          w_src_nxt       = src_addr;
          w_dst_nxt       = dst_addr;
          w_remaining_nxt = len;
          w_state_nxt     = (len == '0) ? DL_FIN : DL_CMD_LO;
        end
      end
      DL_CMD_LO: if (w_cmd_hs) w_state_nxt = DL_RSP_LO;
      DL_RSP_LO: if (icb_rsp_valid) w_state_nxt = icb_rsp_err ? DL_FIN : DL_CMD_HI;
      DL_CMD_HI: if (w_cmd_hs) w_state_nxt = DL_RSP_HI;
      DL_RSP_HI: if (icb_rsp_valid) w_state_nxt = icb_rsp_err ? DL_FIN : DL_WRITE;
      DL_WRITE: begin
        w_src_nxt       = r_src_ptr + SRC_AW'(8);
        w_dst_nxt       = r_dst_ptr + HWPE_AW'(8);
        w_remaining_nxt = r_remaining - LEN_W'(1);
        w_state_nxt     = (w_remaining_nxt == '0) ? DL_FIN : DL_CMD_LO;
      end
      DL_FIN:  w_state_nxt = DL_IDLE;
      default: w_state_nxt = DL_IDLE;
    endcase
  end

  // All handshake/status outputs are decoded from the next state so they are
  // registered yet aligned with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= DL_IDLE;
      r_src_ptr     <= '0;
      r_dst_ptr     <= '0;
      r_remaining   <= '0;
      r_lo          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      icb_cmd_valid <= 1'b0;
      icb_cmd_addr  <= '0;
      dma_wen       <= 1'b0;
      dma_wa        <= '0;
      dma_wd        <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_src_ptr     <= w_src_nxt;
      r_dst_ptr     <= w_dst_nxt;
      r_remaining   <= w_remaining_nxt;
      busy          <= (w_state_nxt != DL_IDLE);
      done          <= (w_state_nxt == DL_FIN);
      icb_cmd_valid <= (w_state_nxt == DL_CMD_LO) || (w_state_nxt == DL_CMD_HI);
      icb_cmd_addr  <= (w_state_nxt == DL_CMD_HI) ? (w_src_nxt + SRC_AW'(4)) : w_src_nxt;
      dma_wen       <= (w_state_nxt == DL_WRITE);

      if (w_accept) begin
        err <= 1'b0;
      end else if (w_in_rsp && icb_rsp_valid && icb_rsp_err) begin
        err <= 1'b1;
      end

      if ((r_state == DL_RSP_LO) && icb_rsp_valid) begin
        r_lo <= icb_rsp_rdata;
      end

      // The high word lands straight in the write-data register; a failed
      // high beat leaves the previous write untouched.
      if ((r_state == DL_RSP_HI) && icb_rsp_valid && !icb_rsp_err) begin
        dma_wa <= r_dst_ptr;
        dma_wd <= {icb_rsp_rdata, r_lo};
      end
    end
  end

endmodule

`default_nettype wire
